// File: rtl/posit_regime_pipe.sv
// posit_regime_pipe
//   Two-stage valid/ready pipeline that turns a signed scale (float exponent)
//   into the regime + exponent bitstring of a posit<N,ES>, sign bit excluded.
//     stage 1: k = scale >>> ES, e = scale[ES-1:0], sign of k
//     stage 2: body (MSB-aligned, zero-filled), regime length, saturation flag
//
// Parameters
//   N    posit width (8..32)
//   ES   exponent-field width (0..3)
//   EXPW width of the signed input scale
//
// Ports
//   clk, rst_n           clock, asynchronous active-low reset
//   in_valid/in_ready    input handshake, in_scale = signed scale
//   out_valid/out_ready  output handshake
//   out_body  [N-2:0]    regime run, terminator, exponent bits, MSB first
//   out_rlen             regime length incl. terminator, clamped to N-1
//   out_sat              scale clamped to maxpos/minpos (only with macro)
//
// Build option
//   POSIT_REGIME_SAT_EN  when defined, out-of-range scales clamp to maxpos
//                        (all ones) or minpos (0...01) and raise out_sat;
//                        when undefined, plain truncation applies and the
//                        out_sat port does not exist.

module posit_regime_pipe #(
    parameter int N    = 16,
    parameter int ES   = 1,
    parameter int EXPW = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [EXPW-1:0]        in_scale,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [N-2:0]           out_body,
    output logic [$clog2(N):0]     out_rlen
`ifdef POSIT_REGIME_SAT_EN
    ,
    output logic                   out_sat
`endif
);

    localparam int W  = N - 1;              // body width
    localparam int RW = $clog2(N) + 1;      // rlen width
    localparam int EW = (ES > 0) ? ES : 1;  // storage width for e
    localparam int AW = EXPW + 1;           // |k| needs one extra bit

    // ------------------------------------------------------------------
    // Handshake: each stage moves when its downstream slot is free.
    // ------------------------------------------------------------------
    logic s1_valid, s2_valid;
    logic s1_adv, s2_adv;

    assign s2_adv    = !s2_valid || out_ready;
    assign s1_adv    = !s1_valid || s2_adv;
    assign in_ready  = s1_adv;
    assign out_valid = s2_valid;

    // ------------------------------------------------------------------
    // Stage 1: split the scale into regime value k and exponent bits e.
    // ------------------------------------------------------------------
    logic signed [EXPW-1:0] k_in;
    logic        [EW-1:0]   e_in;
    logic signed [EXPW-1:0] s1_k;
    logic        [EW-1:0]   s1_e;
    logic                   s1_neg;

    assign k_in = $signed(in_scale) >>> ES;
    assign e_in = (ES > 0) ? in_scale[EW-1:0] : '0;

    // NOTE: sequential state is written with <= so every register samples
    // the pre-edge values of the others; = here would create order races.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_k     <= '0;
            s1_e     <= '0;
            s1_neg   <= 1'b0;
        end else if (s1_adv) begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_k   <= k_in;
                s1_e   <= e_in;
                s1_neg <= k_in[EXPW-1];
            end
        end
    end

    // ------------------------------------------------------------------
    // Stage 2 combinational: the regime is a run of `run` copies of the
    // fill bit (1 for k>=0, 0 for k<0) followed by the opposite terminator
    // and then e. Building {terminator, e, 0...} top-aligned and shifting
    // it right by `run` naturally truncates whatever falls off the bottom.
    // ------------------------------------------------------------------
    logic [AW-1:0] k_ext, abs_k, run;
    logic [W-1:0]  base, mask, body_trunc, body_nxt;
    logic [RW-1:0] rlen_nxt;
    logic          fill, full, sat_nxt;

    // NOTE: every always_comb output is given a default first, so no path
    // through the block leaves a signal unassigned and infers a latch.
    always_comb begin
        k_ext      = {s1_k[EXPW-1], s1_k};
        abs_k      = s1_neg ? (~k_ext + AW'(1)) : k_ext;
        run        = s1_neg ? abs_k : (abs_k + AW'(1));
        fill       = ~s1_neg;
        full       = (run >= AW'(W));
        base       = {s1_neg, {(W-1){1'b0}}} | (W'(s1_e) << (W - 1 - ES));
        mask       = ~({W{1'b1}} >> run);
        body_trunc = full ? {W{fill}} : ((base >> run) | (fill ? mask : '0));
        rlen_nxt   = full ? RW'(W) : RW'(run + AW'(1));
        // k > N-2 for k>=0, or k < -(N-2) for k<0
        sat_nxt    = s1_neg ? full : (run > AW'(W));
        body_nxt   = body_trunc;
`ifdef POSIT_REGIME_SAT_EN
        if (sat_nxt) begin
            body_nxt = s1_neg ? W'(1) : {W{1'b1}};
        end
`endif
    end

    // ------------------------------------------------------------------
    // Stage 2 registers: output holds while stalled (no load unless s2_adv).
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_valid <= 1'b0;
            out_body <= '0;
            out_rlen <= '0;
`ifdef POSIT_REGIME_SAT_EN
            out_sat  <= 1'b0;
`endif
        end else if (s2_adv) begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                out_body <= body_nxt;
                out_rlen <= rlen_nxt;
`ifdef POSIT_REGIME_SAT_EN
                out_sat  <= sat_nxt;
`endif
            end
        end
    end

`ifndef POSIT_REGIME_SAT_EN
    // The saturation condition only matters when the clamp is built in.
    logic unused_sat;
    assign unused_sat = sat_nxt;
`endif

endmodule

// File: tb/tb_posit_regime_pipe.sv
// Self-checking bench for posit_regime_pipe (N=16, ES=1, EXPW=16).
// A bit-by-bit model of the posit regime encoding feeds a scoreboard queue;
// a single negedge monitor compares every transferred output and checks
// that a stalled output holds its value.

module tb_posit_regime_pipe;

    localparam int N    = 16;
    localparam int ES   = 1;
    localparam int EXPW = 16;
    localparam int W    = N - 1;
    localparam int RW   = $clog2(N) + 1;
`ifdef POSIT_REGIME_SAT_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            rst_n;
    logic            in_valid;
    logic            in_ready;
    logic [EXPW-1:0] in_scale;
    logic            out_valid;
    logic            out_ready;
    logic [W-1:0]    out_body;
    logic [RW-1:0]   out_rlen;
`ifdef POSIT_REGIME_SAT_EN
    logic            out_sat;
`endif

    posit_regime_pipe #(.N(N), .ES(ES), .EXPW(EXPW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_scale  (in_scale),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_body  (out_body),
        .out_rlen  (out_rlen)
`ifdef POSIT_REGIME_SAT_EN
        ,
        .out_sat   (out_sat)
`endif
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input longint act, input longint exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model: emit the posit bitstring one bit at a time.
    // ------------------------------------------------------------------
    typedef struct {
        logic [W-1:0] body;
        int           rlen;
        bit           sat;
    } exp_t;

    function automatic exp_t model(input logic [EXPW-1:0] scale);
        exp_t r;
        int s;
        int k;
        int e;
        int pos;
        s      = int'($signed(scale));
        k      = s >>> ES;
        e      = s & ((1 << ES) - 1);
        pos    = W - 1;
        r.body = '0;
        r.sat  = 1'b0;
        if (k >= 0) begin
            for (int i = 0; i <= k && pos >= 0; i++) begin
                r.body[pos] = 1'b1;
                pos--;
            end
        end else begin
            for (int i = 0; i < -k && pos >= 0; i++) pos--;
        end
        if (pos >= 0) begin
            r.body[pos] = (k < 0);
            pos--;
        end
        for (int i = ES - 1; i >= 0 && pos >= 0; i--) begin
            r.body[pos] = e[i];
            pos--;
        end
        r.rlen = (k >= 0) ? k + 2 : -k + 1;
        if (r.rlen > W) r.rlen = W;
        if (SAT && k > N - 2) begin
            r.body = '1;
            r.sat  = 1'b1;
        end
        if (SAT && k < -(N - 2)) begin
            r.body = W'(1);
            r.sat  = 1'b1;
        end
        return r;
    endfunction

    // ------------------------------------------------------------------
    // Monitor / scoreboard (samples on the falling edge).
    // ------------------------------------------------------------------
    exp_t          q[$];
    logic          held_v = 1'b0;
    logic [W-1:0]  held_body;
    logic [RW-1:0] held_rlen;
    int            n_acc = 0;
    int            n_out = 0;

    always @(negedge clk) begin
        exp_t x;
        if (!rst_n) begin
            q.delete();
            held_v = 1'b0;
        end else begin
            if (in_valid && in_ready) begin
                q.push_back(model(in_scale));
                n_acc++;
            end
            if (held_v && out_valid) begin
                check("hold_body", out_body, held_body);
                check("hold_rlen", out_rlen, held_rlen);
            end
            held_v    = out_valid && !out_ready;
            held_body = out_body;
            held_rlen = out_rlen;
            if (out_valid && out_ready) begin
                if (q.size() == 0) begin
                    check("unexpected_output", out_body, -1);
                end else begin
                    x = q.pop_front();
                    check("sb_body", out_body, x.body);
                    check("sb_rlen", out_rlen, x.rlen);
`ifdef POSIT_REGIME_SAT_EN
                    check("sb_sat", out_sat, x.sat);
`endif
                    n_out++;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Stimulus helpers
    // ------------------------------------------------------------------
    bit       pat_en  = 1'b0;
    bit [7:0] rdy_pat = 8'hFF;
    int       pat_idx = 0;

    task automatic tick();
        @(posedge clk);
        #1;
        if (pat_en) begin
            out_ready = rdy_pat[pat_idx % 8];
            pat_idx++;
        end
    endtask

    task automatic push(input logic [EXPW-1:0] v);
        bit acc;
        int guard;
        acc      = 1'b0;
        guard    = 0;
        in_valid = 1'b1;
        in_scale = v;
        while (!acc && guard < 100) begin
            @(negedge clk);
            acc = in_ready;
            tick();
            guard++;
        end
        if (!acc) check("push_timeout", 0, 1);
    endtask

    task automatic drain();
        int guard;
        guard = 0;
        while ((q.size() != 0 || out_valid) && guard < 300) begin
            tick();
            guard++;
        end
        check("drain_empty", q.size(), 0);
    endtask

    // ------------------------------------------------------------------
    // Main sequence
    // ------------------------------------------------------------------
    logic [EXPW-1:0] stream[] = '{16'd5, -16'sd3, 16'd40, -16'sd40, 16'h8000, 16'h7FFF,
                                  16'd28, 16'd29, 16'd30, 16'd31, -16'sd27, -16'sd28,
                                  -16'sd29, -16'sd30, 16'd1, -16'sd1, -16'sd2, 16'd2};
    logic [EXPW-1:0] bp_vals[4] = '{16'd1, 16'd2, 16'd3, 16'd4};

    initial begin
        exp_t m;
        int   accepted;
        int   idx;

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_scale  = '0;
        out_ready = 1'b1;

        // Hand-computed values pin the model itself.
        m = model(16'd0);
        check("model_0_body", m.body, 15'h4000);
        check("model_0_rlen", m.rlen, 2);
        m = model(16'd5);
        check("model_5_body", m.body, 15'h7400);
        check("model_5_rlen", m.rlen, 4);
        m = model(-16'sd3);
        check("model_m3_body", m.body, 15'h1800);
        check("model_m3_rlen", m.rlen, 3);
        m = model(16'd40);
        check("model_40_body", m.body, 15'h7FFF);
        check("model_40_rlen", m.rlen, 15);
        m = model(-16'sd40);
        check("model_m40_body", m.body, SAT ? 15'h0001 : 15'h0000);
        m = model(16'h8000);
        check("model_min_body", m.body, SAT ? 15'h0001 : 15'h0000);
        check("model_min_rlen", m.rlen, 15);
        m = model(16'd28);
        check("model_28_body", m.body, 15'h7FFF);
        check("model_28_sat", m.sat, 0);

        // Reset state
        #2;
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_body", out_body, 0);
        check("rst_out_rlen", out_rlen, 0);
`ifdef POSIT_REGIME_SAT_EN
        check("rst_out_sat", out_sat, 0);
`endif
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // Latency: scale 0 accepted on one edge, out_valid after the next.
        in_valid = 1'b1;
        in_scale = '0;
        @(negedge clk);
        check("lat_accept_ready", in_ready, 1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        check("lat_not_yet", out_valid, 0);
        @(posedge clk);
        #1;
        check("lat_valid", out_valid, 1);
        check("lat_body", out_body, 15'h4000);
        check("lat_rlen", out_rlen, 2);
        tick();
        drain();

        // Directed stream under a fixed backpressure pattern.
        pat_en  = 1'b1;
        rdy_pat = 8'b1011_0110;
        foreach (stream[i]) push(stream[i]);
        in_valid = 1'b0;
        drain();
        rdy_pat = 8'hFF;
        foreach (stream[i]) push(stream[i]);
        in_valid = 1'b0;
        drain();
        pat_en    = 1'b0;
        out_ready = 1'b1;

        // Back-to-back 1..4 with the consumer stalled for 4 cycles.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        accepted  = 0;
        idx       = 0;
        for (int c = 0; c < 4; c++) begin
            in_scale = bp_vals[idx];
            @(negedge clk);
            if (in_ready) begin
                accepted++;
                if (idx < 3) idx++;
            end
            tick();
        end
        check("bp_accepted", accepted, 2);
        @(negedge clk);
        check("bp_in_ready_low", in_ready, 0);
        check("bp_out_valid", out_valid, 1);
        tick();
        out_ready = 1'b1;
        push(bp_vals[2]);
        push(bp_vals[3]);
        in_valid = 1'b0;
        drain();

        // Asynchronous reset with both stages full.
        out_ready = 1'b0;
        push(16'd100);
        push(-16'sd100);
        in_valid = 1'b0;
        check("pre_rst_valid", out_valid, 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_out_valid", out_valid, 0);
        check("arst_out_body", out_body, 0);
        check("arst_out_rlen", out_rlen, 0);
        check("arst_in_ready", in_ready, 1);
`ifdef POSIT_REGIME_SAT_EN
        check("arst_out_sat", out_sat, 0);
`endif
        tick();
        tick();
        @(negedge clk);
        rst_n     = 1'b1;
        out_ready = 1'b1;
        tick();
        tick();
        tick();
        check("post_rst_no_stale", out_valid, 0);
        push(16'd7);
        in_valid = 1'b0;
        drain();
        check("post_rst_outputs", n_out, n_acc - 2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
